// File: rtl/tcdm_varlat_pkg.sv
// Shared definitions for the variable-latency TCDM crossbar slice.
//   idx_width()          : $clog2(n), but never less than 1 bit
//   DefaultNumIn         : default master count
//   DefaultMaxOutstanding: default ID FIFO depth
//   master_idx_t         : master index type for the default master count
package tcdm_varlat_pkg;

  localparam int unsigned DefaultNumIn          = 4;
  localparam int unsigned DefaultMaxOutstanding = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(DefaultNumIn)-1:0] master_idx_t;

endpackage

// File: rtl/bank_resp_id_fifo.sv
// In-order ID FIFO.
// It holds the master index of every granted-but-unanswered transaction.
// Ports:
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata at the tail (ignored when full)
//   wdata    : ID to store
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry (valid while !empty)
//   full     : count == Depth
//   empty    : count == 0
//   count    : number of stored entries
// Push and pop may both be asserted in the same cycle; the count then holds.
module bank_resp_id_fifo
  import tcdm_varlat_pkg::*;
#(
  parameter int unsigned Depth = DefaultMaxOutstanding,
  parameter int unsigned Width = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  output logic [Width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({push_en, pop_en})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bank_arb_resp_demux_varlat.sv
// Bank-side round-robin arbiter and in-order response demux.
// It sits in front of one bank of the variable-latency TCDM crossbar.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   req_i/gnt_o      : per-master request / grant
//   data_i           : per-master packed request payload (NumIn x ReqDataWidth)
//   vld_o/rdata_o    : per-master response valid / data (NumIn x RespDataWidth)
//   req_o/gnt_i      : request to bank / bank grant
//   data_o           : winning master's payload ('0 when nobody requests)
//   vld_i/rdata_i    : bank response valid / data (returned in grant order)
// Build option:
//   BANK_ARB_RDATA_GATE_EN : zero rdata_o lanes whose vld_o is low
//                            (default: rdata_i broadcast to every lane)
module bank_arb_resp_demux_varlat
  import tcdm_varlat_pkg::*;
#(
  parameter int unsigned NumIn          = DefaultNumIn,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumIn-1:0]                 req_i,
  output logic [NumIn-1:0]                 gnt_o,
  input  logic [NumIn*ReqDataWidth-1:0]    data_i,
  output logic [NumIn-1:0]                 vld_o,
  output logic [NumIn*RespDataWidth-1:0]   rdata_o,
  output logic                             req_o,
  input  logic                             gnt_i,
  output logic [ReqDataWidth-1:0]          data_o,
  input  logic                             vld_i,
  input  logic [RespDataWidth-1:0]         rdata_i
);

  localparam int unsigned IdxW = idx_width(NumIn);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;

  idx_t            rr_ptr;
  idx_t            winner;
  logic            found;
  logic            hs;
  logic            pop;
  idx_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] count;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned k;
    k      = 0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      k = (int'(rr_ptr) + i) % NumIn;
      if (!found && req_i[idx_t'(k)]) begin
        found  = 1'b1;
        winner = idx_t'(k);
      end
    end
  end

  // Credit gating: the full flag comes only from registered state, so vld_i
  // has no combinational path to req_o.
  assign req_o = (|req_i) & ~fifo_full & ~rst_i;
  assign hs    = req_o & gnt_i;
  assign pop   = vld_i & ~fifo_empty & ~rst_i;

  always_comb begin
    data_o = '0;
    gnt_o  = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (found && winner == idx_t'(i)) begin
        data_o   = data_i[i*ReqDataWidth +: ReqDataWidth];
        gnt_o[i] = hs;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (winner == idx_t'(NumIn - 1)) ? '0 : winner + idx_t'(1);
    end
  end

  bank_resp_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (hs),
    .wdata (winner),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    vld_o = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      vld_o[i] = pop & (head == idx_t'(i));
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
`ifdef BANK_ARB_RDATA_GATE_EN
      rdata_o[i*RespDataWidth +: RespDataWidth] = vld_o[i] ? rdata_i : '0;
`else
      rdata_o[i*RespDataWidth +: RespDataWidth] = rdata_i;
`endif
    end
  end

  // A response with nothing outstanding is dropped; flag it in simulation.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(vld_i && fifo_empty))
        else $warning("bank_arb_resp_demux_varlat: vld_i with no outstanding ID ignored");
    end
  end

endmodule

// File: tb/tb_bank_arb_resp_demux_varlat.sv
// Directed self-checking bench for bank_arb_resp_demux_varlat (NumIn=4, MaxOutstanding=2).
module tb_bank_arb_resp_demux_varlat;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [3:0]   gnt_o;
  logic [127:0] data_i;
  logic [3:0]   vld_o;
  logic [127:0] rdata_o;
  logic         req_o;
  logic         gnt_i;
  logic [31:0]  data_o;
  logic         vld_i;
  logic [31:0]  rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bank_arb_resp_demux_varlat #(
    .NumIn          (4),
    .ReqDataWidth   (32),
    .RespDataWidth  (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .data_i  (data_i),
    .vld_o   (vld_o),
    .rdata_o (rdata_o),
    .req_o   (req_o),
    .gnt_i   (gnt_i),
    .data_o  (data_o),
    .vld_i   (vld_i),
    .rdata_i (rdata_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    logic [31:0] other_lane;
    rst_i   = 1'b1;
    req_i   = 4'hF;
    gnt_i   = 1'b1;
    vld_i   = 1'b1;
    rdata_i = 32'h1234_5678;
    data_i  = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    // Reset forces the handshake outputs low even with live inputs.
    tick();
    #1;
    chk("rst_req_o", 128'(req_o), 128'(1'b0));
    chk("rst_gnt_o", 128'(gnt_o), 128'(4'b0000));
    chk("rst_vld_o", 128'(vld_o), 128'(4'b0000));
    tick();
    rst_i = 1'b0; req_i = 4'h0; gnt_i = 1'b0; vld_i = 1'b0;
    #1;
    chk("rst_count", 128'(dut.count), 128'(2'd0));
    chk("rst_rr_ptr", 128'(dut.rr_ptr), 128'(2'd0));
    chk("idle_req_o", 128'(req_o), 128'(1'b0));
    chk("idle_data_o", 128'(data_o), 128'(32'h0));

    // Single master 2, two handshakes, responses three cycles later.
    tick();
    req_i = 4'b0100; gnt_i = 1'b1;
    #1;
    chk("m2_req_o", 128'(req_o), 128'(1'b1));
    chk("m2_gnt_a", 128'(gnt_o), 128'(4'b0100));
    chk("m2_data_o", 128'(data_o), 128'(32'hD000_0002));
    tick();
    #1;
    chk("m2_gnt_b", 128'(gnt_o), 128'(4'b0100));
    tick();
    req_i = 4'b0000;
    #1;
    chk("m2_count_full", 128'(dut.count), 128'(2'd2));
    chk("m2_rr_ptr", 128'(dut.rr_ptr), 128'(2'd3));
    tick();
    vld_i = 1'b1; rdata_i = 32'hCAFE_0001;
    #1;
    chk("m2_vld_a", 128'(vld_o), 128'(4'b0100));
    chk("m2_rdata2", 128'(rdata_o[64 +: 32]), 128'(32'hCAFE_0001));
`ifdef BANK_ARB_RDATA_GATE_EN
    other_lane = 32'h0;
`else
    other_lane = 32'hCAFE_0001;
`endif
    chk("m2_rdata0", 128'(rdata_o[0 +: 32]), 128'(other_lane));
    tick();
    rdata_i = 32'hCAFE_0002;
    #1;
    chk("m2_vld_b", 128'(vld_o), 128'(4'b0100));
    tick();
    vld_i = 1'b0;
    #1;
    chk("m2_count_zero", 128'(dut.count), 128'(2'd0));

    // Reset pulse to bring rr_ptr back to 0.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("pulse_rr_ptr", 128'(dut.rr_ptr), 128'(2'd0));

    // All masters requesting; each response one cycle after its grant.
    req_i = 4'hF; gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vld_i   = (i != 0);
      rdata_i = 32'hB000_0000 + i;
      #1;
      chk($sformatf("rr_gnt%0d", i), 128'(gnt_o), 128'(4'b0001 << (i % 4)));
      if (i != 0) chk($sformatf("rr_vld%0d", i), 128'(vld_o), 128'(4'b0001 << ((i - 1) % 4)));
      tick();
      if (i != 0) chk($sformatf("rr_count%0d", i), 128'(dut.count), 128'(2'd1));
    end
    req_i = 4'h0; gnt_i = 1'b0; vld_i = 1'b1;
    #1;
    chk("rr_vld_last", 128'(vld_o), 128'(4'b0001));
    tick();
    vld_i = 1'b0;
    #1;
    chk("rr_count_end", 128'(dut.count), 128'(2'd0));

    // Withheld responses: two grants (1, 2), then stalled on credit.
    req_i = 4'hF; gnt_i = 1'b1;
    #1;
    chk("cr_gnt_a", 128'(gnt_o), 128'(4'b0010));
    tick();
    chk("cr_gnt_b", 128'(gnt_o), 128'(4'b0100));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("cr_stall_req%0d", i), 128'(req_o), 128'(1'b0));
      chk($sformatf("cr_stall_gnt%0d", i), 128'(gnt_o), 128'(4'b0000));
      tick();
    end
    vld_i = 1'b1; rdata_i = 32'hA000_0001;
    #1;
    chk("cr_vld_a", 128'(vld_o), 128'(4'b0010));
    chk("cr_req_same_cycle", 128'(req_o), 128'(1'b0));
    tick();
    vld_i = 1'b0;
    #1;
    chk("cr_req_restored", 128'(req_o), 128'(1'b1));
    chk("cr_gnt_c", 128'(gnt_o), 128'(4'b1000));
    tick();
    vld_i = 1'b1; rdata_i = 32'hA000_0002;
    #1;
    chk("cr_vld_b", 128'(vld_o), 128'(4'b0100));
    tick();
    req_i = 4'h0;
    #1;
    chk("cr_vld_c", 128'(vld_o), 128'(4'b1000));
    tick();
    vld_i = 1'b0;
    #1;
    chk("cr_count_end", 128'(dut.count), 128'(2'd0));

    // Spurious response with nothing outstanding is dropped.
    vld_i = 1'b1;
    #1;
    chk("spur_vld_o", 128'(vld_o), 128'(4'b0000));
    tick();
    vld_i = 1'b0;
    #1;
    chk("spur_count", 128'(dut.count), 128'(2'd0));
    chk("spur_rr_ptr", 128'(dut.rr_ptr), 128'(2'd0));

    // Reset with two IDs outstanding.
    req_i = 4'hF; gnt_i = 1'b1;
    tick();
    tick();
    #1;
    chk("pre_rst_count", 128'(dut.count), 128'(2'd2));
    chk("pre_rst_rr_ptr", 128'(dut.rr_ptr), 128'(2'd2));
    rst_i = 1'b1; vld_i = 1'b1; rdata_i = 32'h5555_AAAA;
    #1;
    chk("mid_rst_gnt", 128'(gnt_o), 128'(4'b0000));
    chk("mid_rst_vld", 128'(vld_o), 128'(4'b0000));
    chk("mid_rst_req", 128'(req_o), 128'(1'b0));
`ifdef BANK_ARB_RDATA_GATE_EN
    chk("mid_rst_rdata", 128'(rdata_o), 128'(0));
`endif
    tick();
    rst_i = 1'b0; req_i = 4'h0; gnt_i = 1'b0;
    #1;
    chk("post_rst_count", 128'(dut.count), 128'(2'd0));
    chk("post_rst_rr_ptr", 128'(dut.rr_ptr), 128'(2'd0));
    chk("post_rst_late_vld", 128'(vld_o), 128'(4'b0000));
    tick();
    vld_i = 1'b0;
    #1;
    chk("post_rst_count2", 128'(dut.count), 128'(2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
